// File: rtl/cpu_pkg.sv
// Shared definitions for the ELEC326 pipeline: word width, opcode field position and
// the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [2:0] {
    StStart,
    StFetch,
    StHold,
    StDrain,
    StHalt
  } fetch_state_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter for taken redirects; sticks at all-ones until reset.
module fetch_perf_counter
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  output logic [WORD_W-1:0] count_o
);

  logic [WORD_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WORD_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time, buffers the
// word for decode and squashes wrong-path work on redirect. FETCH_PERF_CNT_EN adds a
// taken-redirect counter on taken_count_po.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0]   RESET_PC    = 16'h0000,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic              clk_pi,
  input  logic              reset_n_pi,
  input  logic              is_branch_taken_pi,
  input  logic [WORD_W-1:0] branch_target_pi,
  output logic              imem_req_po,
  output logic [WORD_W-1:0] imem_addr_po,
  input  logic              imem_valid_pi,
  input  logic [WORD_W-1:0] imem_data_pi,
  output logic              instr_valid_po,
  output logic [WORD_W-1:0] instr_po,
  output logic [WORD_W-1:0] instr_pc_po,
  input  logic              instr_ready_pi,
  output logic              halted_po,
  output logic [WORD_W-1:0] taken_count_po
);

  fetch_state_t      state_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] req_addr_q;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] instr_pc_q;
  logic              req_q;
  logic              buf_valid_q;
  logic              halted_q;
  logic              xfer;

  // A redirect masks the buffered word so a wrong-path instruction never hands off.
  assign instr_valid_po = buf_valid_q & ~is_branch_taken_pi;
  assign xfer           = instr_valid_po & instr_ready_pi;

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state_q     <= StStart;
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      req_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StStart: begin
          state_q    <= StFetch;
          req_q      <= 1'b1;
          req_addr_q <= pc_q;
        end
        StFetch: begin
          if (is_branch_taken_pi) begin
            pc_q <= branch_target_pi;
            // Response already here: drop it and reissue at the target straight away.
            if (imem_valid_pi) begin
              req_addr_q <= branch_target_pi;
            end else begin
              state_q <= StDrain;
            end
          end else if (imem_valid_pi) begin
            buf_valid_q <= 1'b1;
            instr_q     <= imem_data_pi;
            instr_pc_q  <= pc_q;
            pc_q        <= pc_q + WORD_W'(1);
            req_q       <= 1'b0;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (is_branch_taken_pi) begin
            buf_valid_q <= 1'b0;
            pc_q        <= branch_target_pi;
            req_q       <= 1'b1;
            req_addr_q  <= branch_target_pi;
            state_q     <= StFetch;
          end else if (xfer) begin
            buf_valid_q <= 1'b0;
            if (opcode_of(instr_q) == HALT_OPCODE) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              req_q      <= 1'b1;
              req_addr_q <= pc_q;
              state_q    <= StFetch;
            end
          end
        end
        StDrain: begin
          // Wrong-path request still in flight: keep its address until it returns.
          if (is_branch_taken_pi) begin
            pc_q <= branch_target_pi;
          end
          if (imem_valid_pi) begin
            req_addr_q <= is_branch_taken_pi ? branch_target_pi : pc_q;
            state_q    <= StFetch;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StStart;
        end
      endcase
    end
  end

  assign imem_req_po  = req_q;
  assign imem_addr_po = req_addr_q;
  assign instr_po     = instr_q;
  assign instr_pc_po  = instr_pc_q;
  assign halted_po    = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic redirect;

  assign redirect = is_branch_taken_pi &
                    ((state_q == StFetch) | (state_q == StHold) | (state_q == StDrain));

  fetch_perf_counter u_perf_counter (
    .clk_i   (clk_pi),
    .rst_ni  (reset_n_pi),
    .inc_i   (redirect),
    .count_o (taken_count_po)
  );
`else
  assign taken_count_po = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected requests and decode transfers are queued up
// front; monitors pop and compare as the DUT presents them.
module tb_fetch_unit;

  logic        clk_pi = 1'b0;
  logic        reset_n_pi;
  logic        is_branch_taken_pi;
  logic [15:0] branch_target_pi;
  logic        imem_req_po;
  logic [15:0] imem_addr_po;
  logic        imem_valid_pi;
  logic [15:0] imem_data_pi;
  logic        instr_valid_po;
  logic [15:0] instr_po;
  logic [15:0] instr_pc_po;
  logic        instr_ready_pi;
  logic        halted_po;
  logic [15:0] taken_count_po;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_req_q[$];
  logic [31:0] exp_xfer_q[$];

`ifdef FETCH_PERF_CNT_EN
  localparam logic [15:0] ExpTaken = 16'd3;
`else
  localparam logic [15:0] ExpTaken = 16'd0;
`endif

  fetch_unit dut (
    .clk_pi             (clk_pi),
    .reset_n_pi         (reset_n_pi),
    .is_branch_taken_pi (is_branch_taken_pi),
    .branch_target_pi   (branch_target_pi),
    .imem_req_po        (imem_req_po),
    .imem_addr_po       (imem_addr_po),
    .imem_valid_pi      (imem_valid_pi),
    .imem_data_pi       (imem_data_pi),
    .instr_valid_po     (instr_valid_po),
    .instr_po           (instr_po),
    .instr_pc_po        (instr_pc_po),
    .instr_ready_pi     (instr_ready_pi),
    .halted_po          (halted_po),
    .taken_count_po     (taken_count_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic tick();
    @(posedge clk_pi);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : (16'h1000 | (a & 16'h0FFF));
  endfunction

  // Wait (bounded) until the buffer presents the instruction fetched from pc.
  task automatic wait_hold(input logic [15:0] pc, input string name);
    int n;
    n = 0;
    while (!(instr_valid_po && (instr_pc_po == pc)) && (n < 40)) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 40) begin
      n_err++;
      $display("FAIL %s: buffered instr from %h not seen within 40 cycles, got pc %h", name,
               pc, instr_pc_po);
    end
  endtask

  // Instruction memory: answers each new request after mem_lat cycles.
  initial begin
    logic        pend;
    int          wait_cnt;
    logic [15:0] pend_addr;
    pend          = 1'b0;
    wait_cnt      = 0;
    pend_addr     = '0;
    imem_valid_pi = 1'b0;
    imem_data_pi  = '0;
    forever begin
      tick();
      if (imem_valid_pi) pend = 1'b0;
      imem_valid_pi = 1'b0;
      if (!reset_n_pi) begin
        pend = 1'b0;
      end else if (pend) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          imem_valid_pi = 1'b1;
          imem_data_pi  = mem_rd(pend_addr);
        end
      end else if (imem_req_po) begin
        pend      = 1'b1;
        wait_cnt  = mem_lat;
        pend_addr = imem_addr_po;
      end
    end
  end

  // Request monitor: new requests against the queue, open requests held stable.
  initial begin
    logic        req_open;
    logic [15:0] open_addr;
    logic [15:0] e;
    req_open  = 1'b0;
    open_addr = '0;
    forever begin
      @(negedge clk_pi);
      if (!reset_n_pi) begin
        req_open = 1'b0;
      end else begin
        if (req_open) begin
          chk1("req_held", imem_req_po, 1'b1);
          chk16("req_addr_stable", imem_addr_po, open_addr);
        end else if (imem_req_po) begin
          if (exp_req_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_req: got request %h, expected none", imem_addr_po);
          end else begin
            e = exp_req_q.pop_front();
            chk16("req_addr", imem_addr_po, e);
          end
          req_open  = 1'b1;
          open_addr = imem_addr_po;
        end
        if (imem_valid_pi) req_open = 1'b0;
      end
    end
  end

  // Transfer monitor: every decode handshake against the queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_pi);
      if (reset_n_pi && instr_valid_po && instr_ready_pi) begin
        if (exp_xfer_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_xfer: got %h @%h, expected none", instr_po, instr_pc_po);
        end else begin
          e = exp_xfer_q.pop_front();
          chk16("xfer_instr", instr_po, e[31:16]);
          chk16("xfer_pc", instr_pc_po, e[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_pi         = 1'b0;
    is_branch_taken_pi = 1'b0;
    branch_target_pi   = '0;
    instr_ready_pi     = 1'b1;

    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h5678;
    mem[16'h0002] = 16'hABCD;
    mem[16'h0003] = 16'hDEAD;
    mem[16'h0040] = 16'h2040;
    mem[16'hFFFF] = 16'h7FFF;

    exp_req_q  = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0040, 16'h0041, 16'h0100,
                   16'hFFFF, 16'h0000};
    exp_xfer_q = '{{16'h1234, 16'h0000}, {16'h5678, 16'h0001}, {16'hABCD, 16'h0002},
                   {16'h2040, 16'h0040}, {16'h7FFF, 16'hFFFF}, {16'hF000, 16'h0000}};

    repeat (3) tick();
    chk1("rst_req", imem_req_po, 1'b0);
    chk16("rst_addr", imem_addr_po, 16'h0000);
    chk1("rst_instr_valid", instr_valid_po, 1'b0);
    chk16("rst_instr", instr_po, 16'h0000);
    chk16("rst_instr_pc", instr_pc_po, 16'h0000);
    chk1("rst_halted", halted_po, 1'b0);
    chk16("rst_taken_count", taken_count_po, 16'h0000);

    reset_n_pi = 1'b1;
    chk1("start_no_req", imem_req_po, 1'b0);
    tick();
    chk1("first_req", imem_req_po, 1'b1);
    chk16("first_addr", imem_addr_po, 16'h0000);

    // Stall decode with the word from 0002 buffered.
    wait_hold(16'h0002, "wait_hold_0002");
    instr_ready_pi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("stall_valid", instr_valid_po, 1'b1);
      chk16("stall_instr", instr_po, 16'hABCD);
      chk16("stall_pc", instr_pc_po, 16'h0002);
      chk1("stall_no_req", imem_req_po, 1'b0);
      tick();
    end

    // Redirect while FETCH waits on a 3-cycle memory.
    mem_lat        = 3;
    instr_ready_pi = 1'b1;
    tick();
    chk1("fetch3_req", imem_req_po, 1'b1);
    chk16("fetch3_addr", imem_addr_po, 16'h0003);
    is_branch_taken_pi = 1'b1;
    branch_target_pi   = 16'h0040;
    tick();
    is_branch_taken_pi = 1'b0;
    chk1("drain_req", imem_req_po, 1'b1);
    chk16("drain_addr", imem_addr_po, 16'h0003);
    chk1("drain_no_valid", instr_valid_po, 1'b0);
    mem_lat = 1;

    wait_hold(16'h0040, "wait_hold_0040");

    // Redirect in HOLD with decode ready: the buffered word must not transfer.
    wait_hold(16'h0041, "wait_hold_0041");
    is_branch_taken_pi = 1'b1;
    branch_target_pi   = 16'h0100;
    tick();
    is_branch_taken_pi = 1'b0;
    chk1("hold_redir_req", imem_req_po, 1'b1);
    chk16("hold_redir_addr", imem_addr_po, 16'h0100);

    // Jump to FFFF to exercise PC wrap; the word at 0000 is now a halt.
    wait_hold(16'h0100, "wait_hold_0100");
    mem[16'h0000]      = 16'hF000;
    is_branch_taken_pi = 1'b1;
    branch_target_pi   = 16'hFFFF;
    tick();
    is_branch_taken_pi = 1'b0;
    chk16("redir_ffff_addr", imem_addr_po, 16'hFFFF);

    wait_hold(16'hFFFF, "wait_hold_ffff");
    tick();
    chk1("wrap_req", imem_req_po, 1'b1);
    chk16("wrap_addr", imem_addr_po, 16'h0000);

    wait_hold(16'h0000, "wait_hold_halt");
    chk1("pre_halt", halted_po, 1'b0);
    tick();
    chk1("halted", halted_po, 1'b1);
    chk1("halt_no_req", imem_req_po, 1'b0);
    chk1("halt_no_valid", instr_valid_po, 1'b0);
    is_branch_taken_pi = 1'b1;
    branch_target_pi   = 16'h0300;
    tick();
    is_branch_taken_pi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("halt_ignore_redir_req", imem_req_po, 1'b0);
      chk1("halt_stays", halted_po, 1'b1);
      tick();
    end
    chk16("taken_count", taken_count_po, ExpTaken);

    chk16("req_q_left", 16'(exp_req_q.size()), 16'h0000);
    chk16("xfer_q_left", 16'(exp_xfer_q.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit ELEC326 processor, directly downstream of `branch`. It owns the program counter and fetches one instruction at a time from instruction memory using a request/valid handshake. It buffers the instruction and presents it to decode using valid/ready. When `is_branch_taken` rises, it redirects the PC to the resolved target and squashes all wrong-path work.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value after reset.
- `HALT_OPCODE`, default 4'hF: value of instruction bits [15:12] that halts fetch.

Ports:
- `clk_pi` input 1: single clock; all state updates on its rising edge.
- `reset_n_pi` input 1: reset, asynchronous and active-low.
- `is_branch_taken_pi` input 1: redirect request, driven by `branch.is_branch_taken_po`.
- `branch_target_pi` input 16: resolved branch target. Valid when `is_branch_taken_pi`=1.
- `imem_req_po` output 1: fetch request.
- `imem_addr_po` output 16: word address of the request (the current PC).
- `imem_valid_pi` input 1: response valid; one pulse per request.
- `imem_data_pi` input 16: instruction word; valid with `imem_valid_pi`.
- `instr_valid_po` output 1: buffered instruction available to decode.
- `instr_po` output 16: buffered instruction.
- `instr_pc_po` output 16: address the buffered instruction was fetched from.
- `instr_ready_pi` input 1: decode accepts the instruction.
- `halted_po` output 1: fetch is stopped on a halt instruction.
- `taken_count_po` output 16: count of taken redirects (see Configuration).

## Operation
- PC is word-addressed and increments by 1 per fetched instruction. Increment wraps 16'hFFFF→16'h0000.
- States:
  - START: reset state. Drives no request. Unconditionally goes to FETCH on the next cycle.
  - FETCH: `imem_req_po`=1 and `imem_addr_po`=PC.
    - On `imem_valid_pi`: capture data into the buffer, set `instr_pc`=PC, set PC=PC+1, go to HOLD.
    - With no response, stay in FETCH.
  - HOLD: buffer is full. On a valid/ready transfer, go to HALT if instr[15:12]==`HALT_OPCODE`, otherwise go to FETCH.
  - DRAIN: one wrong-path request is still outstanding. Keep `imem_req_po`=1 with the address stable. On `imem_valid_pi`, discard the data and go to FETCH.
  - HALT: `halted_po`=1 and no requests. Exit only through reset.
- Memory protocol:
  - `imem_req_po` and `imem_addr_po` stay stable until `imem_valid_pi` is seen.
  - The response arrives at least 1 cycle after the request first rises.
  - At most one request is outstanding.
- Redirect (`is_branch_taken_pi`=1) has highest priority after reset. PC is set to `branch_target_pi`.
  - In FETCH without valid: go to DRAIN.
  - In FETCH with valid in the same cycle: discard the data and stay in FETCH. The new request uses the target address.
  - In HOLD: drop the buffer and go to FETCH.
  - In DRAIN: update PC and stay in DRAIN. If valid arrives in the same cycle, go to FETCH.
  - In HALT or START: ignore the redirect.
- `instr_valid_po` = buffer_valid & ~`is_branch_taken_pi`. A wrong-path instruction can never complete a handshake.
- A halt instruction is still delivered to decode before the unit enters HALT.

## Timing
- Reset values: state=START, PC=`RESET_PC`. All outputs are 0: `imem_req_po`, `imem_addr_po`, `instr_valid_po`, `instr_po`, `instr_pc_po`, `halted_po`, `taken_count_po`.
- First request is in the cycle after reset deasserts. `imem_addr_po`=`RESET_PC`.
- With a 1-cycle memory and decode always ready, the pattern is FETCH, FETCH(valid), HOLD(transfer), repeating. Throughput is 1 instruction per 3 cycles.
- Redirect-to-target-request latency:
  - 1 cycle from HOLD, or from FETCH with valid in the same cycle.
  - From FETCH without valid: the remaining memory latency, plus 1 cycle.
- Reset asserted mid-operation forces START immediately. Instruction memory shares `reset_n_pi` and discards its outstanding request.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `taken_count_po` increments on every cycle where a redirect is applied (states FETCH, HOLD, DRAIN).
  - It saturates at 16'hFFFF and resets to 0.
- Not defined: `taken_count_po` is tied to 16'h0000 and no counter flops exist.

## Structure
- Shared package `cpu_pkg` holds:
  - the `fetch_state_t` enum (START, FETCH, HOLD, DRAIN, HALT);
  - the `OPCODE_MSB`/`OPCODE_LSB` constants;
  - the default `HALT_OPCODE`;
  - the `WORD_W`=16 constant.
- One sub-module: `fetch_perf_counter`, the saturating counter. It is instantiated only under `FETCH_PERF_CNT_EN`.

## Test plan
- Reset, then 1-cycle memory returns 16'h1234 @0000 and 16'h5678 @0001, decode always ready.
  - Expect addresses 0000, 0001, 0002.
  - Expect `instr_pc_po` 0000 then 0001, each transfer exactly once.
- Decode stalls `instr_ready_pi`=0 for 4 cycles in HOLD. Expect `instr_po`/`instr_pc_po` held and no new `imem_req_po`.
- Redirect to 16'h0040 while in FETCH with a 3-cycle memory. Expect DRAIN, the stale data discarded, then a request to 0040.
- Redirect to 16'h0100 in HOLD with `instr_ready_pi`=1 in the same cycle. Expect no transfer and the next request to 0100.
- PC=FFFF. Expect the next request at 0000.
- Instruction 16'hF000 (halt) is delivered and accepted.
  - Expect `halted_po`=1 from the next cycle and no further requests.
  - A redirect is ignored.
  - With `FETCH_PERF_CNT_EN` defined, `taken_count_po` equals the number of earlier redirects.
